trng_health_fifo: RTL and testbench

- Downstream consumer of the TRNG/PUF entropy core's 64-bit sample readout (ready/read handshake).
- Runs online health tests on every sample: a repetition-count test (RCT) on whole 64-bit words and an adaptive-proportion test (APT) on the ones-count over a window of samples.
- Passing samples go into a small FIFO that the TinyQV peripheral wrapper pops as two 32-bit register reads. Failures raise a sticky alarm.

---
 rtl/trng_pkg.sv | 25 ++
 rtl/trng_health_fifo_if.sv | 22 ++
 rtl/trng_sample_fifo.sv | 69 ++++++
 rtl/trng_health_fifo.sv | 148 ++++++++++++++
 tb/tb_trng_health_fifo.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trng_pkg.sv
// trng_pkg: shared sample width, popcount helper and
// default health-test thresholds for trng_health_fifo.
package trng_pkg;

  localparam int SAMPLE_W       = 64;
  localparam int PCNT_W         = 7;
  localparam int SUM_W          = 11;
  localparam int RCT_CUTOFF_DEF = 3;
  localparam int APT_WINDOW_DEF = 16;
  localparam int APT_LO_DEF     = 448;
  localparam int APT_HI_DEF     = 576;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [PCNT_W-1:0]   pcnt_t;
  typedef logic [SUM_W-1:0]    apt_sum_t;

  function automatic pcnt_t popcount(input sample_t s);
    pcnt_t c;
    c = '0;
    for (int i = 0; i < SAMPLE_W; i++)
      c = c + pcnt_t'(s[i]);
    return c;
  endfunction

endpackage

// File: rtl/trng_health_fifo_if.sv
// trng_health_fifo_if: upstream sample channel,
// ready/read handshake carrying one 64-bit sample.
interface trng_health_fifo_if;
  import trng_pkg::*;

  logic    smp_ready_i;
  sample_t smp_i;
  logic    smp_read_o;

  modport master (
    output smp_ready_i,
    output smp_i,
    input  smp_read_o
  );

  modport slave (
    input  smp_ready_i,
    input  smp_i,
    output smp_read_o
  );

endinterface

// File: rtl/trng_sample_fifo.sv
// trng_sample_fifo: circular 64-bit FIFO with occupancy,
// zero-latency head output and synchronous clear.
module trng_sample_fifo
  import trng_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   wr_i,
  input  sample_t                din_i,
  input  logic                   rd_i,
  output sample_t                dout_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  sample_t       mem_q [DEPTH];
  logic [AW-1:0] rp_q;
  logic [AW-1:0] wp_q;
  logic [CW-1:0] cnt_q;
  logic          do_rd;
  logic          do_wr;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_rd   = rd_i & ~empty_o;
  assign do_wr   = wr_i & (~full_o | do_rd);
  assign dout_o  = empty_o ? '0 : mem_q[rp_q];
  assign count_o = cnt_q;

  // pointers and occupancy; clear beats any same-cycle access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_rd) rp_q <= rp_q + 1'b1;
      if (do_wr) wp_q <= wp_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // sample storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (do_wr && !clr_i) begin
      mem_q[wp_q] <= din_i;
    end
  end

endmodule

// File: rtl/trng_health_fifo.sv
// trng_health_fifo: RCT/APT health tests on TRNG samples
// feeding a FIFO; optional irq via TRNG_HEALTH_IRQ_EN.
module trng_health_fifo
  import trng_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int RCT_CUTOFF = RCT_CUTOFF_DEF,
  parameter int APT_WINDOW = APT_WINDOW_DEF,
  parameter int APT_LO     = APT_LO_DEF,
  parameter int APT_HI     = APT_HI_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   clr_i,
  trng_health_fifo_if.slave      smp_if,
  input  logic                   pop_i,
  output sample_t                dout_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   rct_alarm_o,
  output logic                   apt_alarm_o,
  output logic                   irq_o
);

  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int IW = $clog2(APT_WINDOW);
  localparam logic [RW-1:0] RCT_LIM = RW'(RCT_CUTOFF);
  localparam apt_sum_t APT_LO_V = SUM_W'(APT_LO);
  localparam apt_sum_t APT_HI_V = SUM_W'(APT_HI);

  sample_t       stage_q;
  sample_t       last_q;
  logic          stage_v_q;
  logic          last_v_q;
  logic [RW-1:0] rct_q;
  logic [RW-1:0] rct_d;
  apt_sum_t      apt_sum_q;
  apt_sum_t      apt_sum_d;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;
  logic          rct_alarm_q;
  logic          apt_alarm_q;
  logic          alarm;
  logic          full;
  logic          req;
  logic          take;
  logic          trip;
  logic          apt_bad;
  logic          wr;

  assign alarm = rct_alarm_q | apt_alarm_q;
  assign req   = en_i & ~alarm & ~stage_v_q & ~full;
  assign take  = req & smp_if.smp_ready_i;
  assign wr    = stage_v_q & ~trip;

  assign smp_if.smp_read_o = req;
  assign rct_alarm_o       = rct_alarm_q;
  assign apt_alarm_o       = apt_alarm_q;

  // health-test evaluation of the staged sample
  always_comb begin
    rct_d     = rct_q;
    apt_sum_d = apt_sum_q;
    idx_d     = idx_q;
    trip      = 1'b0;
    apt_bad   = 1'b0;
    if (stage_v_q) begin
      if (last_v_q && (stage_q == last_q))
        rct_d = rct_q + 1'b1;
      else
        rct_d = RW'(1);
      trip      = (rct_d >= RCT_LIM);
      apt_sum_d = apt_sum_q + SUM_W'(popcount(stage_q));
      idx_d     = idx_q + 1'b1;
      if (idx_d == '0) begin
        apt_bad   = (apt_sum_d < APT_LO_V) |
                    (apt_sum_d > APT_HI_V);
        apt_sum_d = '0;
      end
    end
  end

  // stage capture, test counters and sticky alarms
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q     <= '0;
      stage_v_q   <= 1'b0;
      last_q      <= '0;
      last_v_q    <= 1'b0;
      rct_q       <= '0;
      apt_sum_q   <= '0;
      idx_q       <= '0;
      rct_alarm_q <= 1'b0;
      apt_alarm_q <= 1'b0;
    end else if (clr_i) begin
      stage_v_q   <= 1'b0;
      last_v_q    <= 1'b0;
      rct_q       <= '0;
      apt_sum_q   <= '0;
      idx_q       <= '0;
      rct_alarm_q <= 1'b0;
      apt_alarm_q <= 1'b0;
    end else begin
      stage_v_q <= take;
      if (take) stage_q <= smp_if.smp_i;
      if (stage_v_q) begin
        last_q    <= stage_q;
        last_v_q  <= 1'b1;
        rct_q     <= rct_d;
        apt_sum_q <= apt_sum_d;
        idx_q     <= idx_d;
      end
      if (trip)    rct_alarm_q <= 1'b1;
      if (apt_bad) apt_alarm_q <= 1'b1;
    end
  end

  trng_sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr_i),
    .wr_i    (wr),
    .din_i   (stage_q),
    .rd_i    (pop_i),
    .dout_o  (dout_o),
    .empty_o (empty_o),
    .full_o  (full),
    .count_o (count_o)
  );

`ifdef TRNG_HEALTH_IRQ_EN
  logic irq_q;

  // interrupt follows alarm-or-full one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= alarm | full;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_trng_health_fifo.sv
// tb_trng_health_fifo: scoreboard bench with an APT
// vector table and hand-written RCT/FIFO/clear sequences.
module tb_trng_health_fifo;
  import trng_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    sample_t a;
    sample_t b;
    logic    exp_apt;
  } apt_vec_t;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    en = 1'b0;
  logic    clr = 1'b0;
  logic    pop = 1'b0;
  sample_t dout;
  logic    empty;
  logic    rct_a;
  logic    apt_a;
  logic    irq;
  logic [2:0] count;

  int n_tests = 0;
  int n_fail = 0;

  sample_t src_q[$];
  sample_t sb_q[$];
  sample_t m_last;
  logic    m_last_v = 1'b0;
  int      m_rct = 0;
  logic    cap_last = 1'b0;

  apt_vec_t vt[7];

  trng_health_fifo_if u_if ();

  trng_health_fifo #(
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en),
    .clr_i       (clr),
    .smp_if      (u_if.slave),
    .pop_i       (pop),
    .dout_o      (dout),
    .empty_o     (empty),
    .count_o     (count),
    .rct_alarm_o (rct_a),
    .apt_alarm_o (apt_a),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    logic    cap;
    logic    irq_nx;
    sample_t s;
    u_if.smp_ready_i = (src_q.size() > 0);
    u_if.smp_i = (src_q.size() > 0) ? src_q[0] : '0;
    #1;
    cap = u_if.smp_read_o & u_if.smp_ready_i;
    if (pop && !empty) begin
      if (sb_q.size() == 0) begin
        chk("pop extra entry", 64'(sb_q.size()), 64'd1);
      end else begin
        s = sb_q.pop_front();
        chk("dout", dout, s);
      end
    end
    irq_nx = rct_a | apt_a | (count == 3'(DEPTH));
    @(posedge clk);
    #1;
    if (cap) s = src_q.pop_front();
    if (clr) begin
      sb_q.delete();
      m_last_v = 1'b0;
      m_rct = 0;
    end else if (cap) begin
      if (m_last_v && s == m_last) m_rct++;
      else m_rct = 1;
      m_last = s;
      m_last_v = 1'b1;
      if (m_rct < 3) sb_q.push_back(s);
    end
`ifdef TRNG_HEALTH_IRQ_EN
    chk("irq", irq, irq_nx);
`else
    chk("irq", irq, 1'b0);
`endif
    cap_last = cap;
  endtask

  task automatic run(input string name);
    int n = 0;
    while (src_q.size() > 0 && n < 200) begin
      step();
      n++;
    end
    chk({name, " src drained"}, src_q.size(), 0);
    src_q.delete();
    repeat (3) step();
  endtask

  task automatic drain(input string name);
    int n = 0;
    pop = 1'b1;
    while (!empty && n < 40) begin
      step();
      n++;
    end
    pop = 1'b0;
    chk({name, " empty"}, empty, 1'b1);
    chk({name, " sb left"}, sb_q.size(), 0);
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    int n;
    int ncap;
    vt[0] = '{64'h5555_5555_5555_5555,
              64'hAAAA_AAAA_AAAA_AAAA, 1'b0};
    vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
    vt[2] = '{64'h0, 64'h1, 1'b1};
    vt[3] = '{64'h0000_0000_0FFF_FFFF,
              64'h0000_0000_FFFF_FFF0, 1'b0};
    vt[4] = '{64'h0000_0000_07FF_FFFF,
              64'h0000_0000_FFFF_FFF0, 1'b1};
    vt[5] = '{64'h0000_000F_FFFF_FFFF,
              64'h0000_00FF_FFFF_FFF0, 1'b0};
    vt[6] = '{64'h0000_001F_FFFF_FFFF,
              64'h0000_00FF_FFFF_FFF0, 1'b1};

    u_if.smp_ready_i = 1'b0;
    u_if.smp_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst empty", empty, 1'b1);
    chk("rst count", count, 0);
    chk("rst dout", dout, 0);
    chk("rst rct", rct_a, 1'b0);
    chk("rst apt", apt_a, 1'b0);
    chk("rst irq", irq, 1'b0);
    chk("rst req", u_if.smp_read_o, 1'b0);
    rst_n = 1'b1;
    step();
    chk("idle req", u_if.smp_read_o, 1'b0);
    en = 1'b1;
    #1;
    chk("en req", u_if.smp_read_o, 1'b1);

    src_q.push_back(64'h5555_5555_5555_5555);
    src_q.push_back(64'hAAAA_AAAA_AAAA_AAAA);
    src_q.push_back(64'h3333_3333_3333_3333);
    src_q.push_back(64'hCCCC_CCCC_CCCC_CCCC);
    run("s1");
    chk("s1 count", count, 4);
    chk("s1 req full", u_if.smp_read_o, 1'b0);
    chk("s1 head", dout, 64'h5555_5555_5555_5555);
    drain("s1");

    clr_pulse();
    repeat (3) src_q.push_back(64'hDEAD_BEEF_0000_0001);
    ncap = 0;
    n = 0;
    while (ncap < 3 && n < 50) begin
      step();
      if (cap_last) ncap++;
      n++;
    end
    chk("s2 captures", ncap, 3);
    chk("s2 rct pre", rct_a, 1'b0);
    step();
    chk("s2 rct trip", rct_a, 1'b1);
    chk("s2 count", count, 2);
    repeat (3) step();
    chk("s2 req blocked", u_if.smp_read_o, 1'b0);
    chk("s2 count hold", count, 2);
    chk("s2 apt", apt_a, 1'b0);
    drain("s2");
    chk("s2 rct sticky", rct_a, 1'b1);

    for (int i = 0; i < 7; i++) begin
      clr_pulse();
      for (int k = 0; k < 8; k++) begin
        src_q.push_back(vt[i].a);
        src_q.push_back(vt[i].b);
      end
      pop = 1'b1;
      run("apt");
      chk("apt alarm", apt_a, vt[i].exp_apt);
      chk("apt rct", rct_a, 1'b0);
      drain("apt");
    end

    clr_pulse();
    src_q.push_back(64'h1111_0000_0000_0001);
    src_q.push_back(64'h2222_0000_0000_0002);
    src_q.push_back(64'h3333_0000_0000_0003);
    src_q.push_back(64'h4444_0000_0000_0004);
    run("s4");
    chk("s4 full", count, 4);
    chk("s4 req full", u_if.smp_read_o, 1'b0);
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("s4 after pop", count, 3);
    src_q.push_back(64'h5555_0000_0000_0005);
    cap_last = 1'b0;
    n = 0;
    while (!cap_last && n < 20) begin
      step();
      n++;
    end
    chk("s4 cap", cap_last, 1'b1);
    chk("s4 cap count", count, 3);
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("s4 wr+pop count", count, 3);
    chk("s4 head adv", dout, 64'h3333_0000_0000_0003);
    src_q.push_back(64'h6666_0000_0000_0006);
    run("s4b");
    chk("s4 refull", count, 4);
    drain("s4");
    pop = 1'b1;
    repeat (2) step();
    pop = 1'b0;
    chk("s4 empty pop count", count, 0);
    chk("s4 empty pop flag", empty, 1'b1);

    clr_pulse();
    src_q.push_back(64'h0BBB_0000_0000_000B);
    repeat (3) src_q.push_back(64'h0AAA_0000_0000_000A);
    run("s5");
    chk("s5 rct", rct_a, 1'b1);
    chk("s5 count", count, 3);
    clr_pulse();
    chk("s5 clr count", count, 0);
    chk("s5 clr rct", rct_a, 1'b0);
    chk("s5 clr apt", apt_a, 1'b0);
    chk("s5 clr empty", empty, 1'b1);
    src_q.push_back(64'h0777_0000_0000_0007);
    src_q.push_back(64'h0888_0000_0000_0008);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("s5 clr cap", cap_last, 1'b1);
    chk("s5 clr cap count", count, 0);
    chk("s5 req resume", u_if.smp_read_o, 1'b1);
    run("s5c");
    chk("s5 one kept", count, 1);
    chk("s5 kept head", dout, 64'h0888_0000_0000_0008);
    drain("s5c");

    clr_pulse();
    src_q.push_back(64'h0123_0000_0000_0001);
    src_q.push_back(64'h0456_0000_0000_0002);
    run("mr");
    chk("mr count pre", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr count", count, 0);
    chk("mr empty", empty, 1'b1);
    chk("mr dout", dout, 0);
    sb_q.delete();
    m_last_v = 1'b0;
    m_rct = 0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step();
    chk("mr req", u_if.smp_read_o, 1'b1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
